// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit flag-producing ALU and the blocks that
// sit downstream of it.
//   ALU_WIDTH      : width of the ALU sum
//   FLAG_*         : bit positions inside alu_flags_t
//                    {sign, zero, carry, parity, overflow} = bits 4..0
//   alu_flags_t    : 5-bit packed flag vector
//   alu_result_t   : {sum, flags} as produced by the ALU in one cycle
//   pack_flags()   : builds an alu_flags_t from the individual flag wires
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH   = 16;
    localparam int FLAG_W      = 5;

    localparam int FLAG_SIGN   = 4;
    localparam int FLAG_ZERO   = 3;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_OVF    = 0;

    typedef logic [FLAG_W-1:0] alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] sum;
        alu_flags_t           flags;
    } alu_result_t;

    // Places each flag at its fixed index so callers never depend on
    // concatenation order.
    function automatic alu_flags_t pack_flags(
        input logic sign,
        input logic zero,
        input logic carry,
        input logic parity,
        input logic overflow
    );
        alu_flags_t f;
        f              = '0;
        f[FLAG_SIGN]   = sign;
        f[FLAG_ZERO]   = zero;
        f[FLAG_CARRY]  = carry;
        f[FLAG_PARITY] = parity;
        f[FLAG_OVF]    = overflow;
        return f;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that counts up by one per inc pulse and sticks at its
// all-ones value instead of wrapping. A clear in the same cycle as an
// increment leaves the counter at 1, so that event is not lost.
//   Parameters: W     - counter width
//   Ports:      clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               clr   - clear to zero (or to one together with inc)
//               inc   - count one event
//               count - current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = inc ? W'(1) : '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/alu_flag_capture.sv
// ---------------------------------------------------------------------------
// alu_flag_capture
// First register stage after the combinational ALU. Each accepted ALU result
// {sum, flags} goes into a 2-entry skid buffer (head/tail registers, FIFO
// order) that is drained through a valid/ready handshake. Alongside the data
// path the block keeps sticky carry/overflow bits and two saturating event
// counters for software readback.
//   Parameters: WIDTH  - datapath width (keep equal to the ALU sum width)
//               CNT_W  - width of each event counter
//   Ports:      clk, rst_n          - clock, synchronous active-low reset
//               in_valid / in_ready - ALU-side handshake (in_ready registered)
//               sum, sign, zero, carry, parity, overflow - ALU outputs
//               out_valid / out_ready - consumer-side handshake
//               out_sum, out_flags  - head entry ({sign,zero,carry,parity,ovf})
//               clr_stat            - clears sticky bits and counters
//               sticky_flags        - {carry_seen, overflow_seen}
//               carry_count, ovf_count - saturating event counts
// ---------------------------------------------------------------------------
module alu_flag_capture
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             sign,
    input  logic             zero,
    input  logic             carry,
    input  logic             parity,
    input  logic             overflow,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [4:0]       out_flags,

    input  logic             clr_stat,
    output logic [1:0]       sticky_flags,
    output logic [CNT_W-1:0] carry_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int CNT_CARRY = 0;
    localparam int CNT_OVF   = 1;
    localparam int NUM_CNT   = 2;

    // ---------------------------------------------------------------------
    // Buffer state
    // ---------------------------------------------------------------------
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             in_ready_reg;
    logic             in_ready_next;
    logic [WIDTH-1:0] head_sum_reg;
    logic [WIDTH-1:0] head_sum_next;
    logic [WIDTH-1:0] tail_sum_reg;
    logic [WIDTH-1:0] tail_sum_next;
    alu_flags_t       head_flags_reg;
    alu_flags_t       head_flags_next;
    alu_flags_t       tail_flags_reg;
    alu_flags_t       tail_flags_next;

    logic             carry_seen_reg;
    logic             carry_seen_next;
    logic             overflow_seen_reg;
    logic             overflow_seen_next;

    alu_flags_t       in_flags;
    logic             push;
    logic             pop;

    assign in_flags = pack_flags(sign, zero, carry, parity, overflow);

    // in_ready_reg is zero throughout reset, so a handshake during reset can
    // never push; pops during reset are overridden by the reset branch.
    assign push = in_valid && in_ready_reg;
    assign pop  = (occ_reg != 2'd0) && out_ready;

    // ---------------------------------------------------------------------
    // Next-state for the 2-entry FIFO. The head register always holds the
    // oldest entry so the outputs come straight from a flop.
    // ---------------------------------------------------------------------
    always_comb begin
        occ_next        = occ_reg;
        head_sum_next   = head_sum_reg;
        head_flags_next = head_flags_reg;
        tail_sum_next   = tail_sum_reg;
        tail_flags_next = tail_flags_reg;

        unique case ({push, pop})
            2'b10: begin
                if (occ_reg == 2'd0) begin
                    head_sum_next   = sum;
                    head_flags_next = in_flags;
                end else begin
                    tail_sum_next   = sum;
                    tail_flags_next = in_flags;
                end
                occ_next = occ_reg + 2'd1;
            end
            2'b01: begin
                // Promote the tail only if one exists; popping the last
                // entry leaves the (now invalid) head contents untouched.
                if (occ_reg == 2'd2) begin
                    head_sum_next   = tail_sum_reg;
                    head_flags_next = tail_flags_reg;
                end
                occ_next = occ_reg - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new entry lands behind the
                // one that remains after the pop.
                if (occ_reg == 2'd1) begin
                    head_sum_next   = sum;
                    head_flags_next = in_flags;
                end else begin
                    head_sum_next   = tail_sum_reg;
                    head_flags_next = tail_flags_reg;
                    tail_sum_next   = sum;
                    tail_flags_next = in_flags;
                end
            end
            default: begin
            end
        endcase

        // Registered ready: reflects the occupancy that will exist after
        // this edge, so a full buffer blocks the very next cycle.
        in_ready_next = (occ_next != 2'd2);
    end

    // ---------------------------------------------------------------------
    // Sticky status: a clear and a setting push in the same cycle leaves
    // the bit set.
    // ---------------------------------------------------------------------
    always_comb begin
        carry_seen_next    = (clr_stat ? 1'b0 : carry_seen_reg)
                           | (push & in_flags[FLAG_CARRY]);
        overflow_seen_next = (clr_stat ? 1'b0 : overflow_seen_reg)
                           | (push & in_flags[FLAG_OVF]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_reg           <= 2'd0;
            in_ready_reg      <= 1'b0;
            head_sum_reg      <= '0;
            head_flags_reg    <= '0;
            tail_sum_reg      <= '0;
            tail_flags_reg    <= '0;
            carry_seen_reg    <= 1'b0;
            overflow_seen_reg <= 1'b0;
        end else begin
            occ_reg           <= occ_next;
            in_ready_reg      <= in_ready_next;
            head_sum_reg      <= head_sum_next;
            head_flags_reg    <= head_flags_next;
            tail_sum_reg      <= tail_sum_next;
            tail_flags_reg    <= tail_flags_next;
            carry_seen_reg    <= carry_seen_next;
            overflow_seen_reg <= overflow_seen_next;
        end
    end

    // ---------------------------------------------------------------------
    // Event counters, one per counted flag.
    // ---------------------------------------------------------------------
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    assign cnt_inc[CNT_CARRY] = push & in_flags[FLAG_CARRY];
    assign cnt_inc[CNT_OVF]   = push & in_flags[FLAG_OVF];

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_sat_counter (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_stat),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign in_ready     = in_ready_reg;
    assign out_valid    = (occ_reg != 2'd0);
    assign out_sum      = head_sum_reg;
    assign out_flags    = head_flags_reg;
    assign sticky_flags = {carry_seen_reg, overflow_seen_reg};
    assign carry_count  = cnt_val[CNT_CARRY];
    assign ovf_count    = cnt_val[CNT_OVF];

endmodule

// File: tb/tb_alu_flag_capture.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_capture
// Directed bench for alu_flag_capture. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, i.e. after the edge has
// settled. Flag vectors are written as {sign, zero, carry, parity, overflow}.
// ---------------------------------------------------------------------------
module tb_alu_flag_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        sign, zero, carry, parity, overflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [4:0]  out_flags;
    logic        clr_stat;
    logic [1:0]  sticky_flags;
    logic [7:0]  carry_count;
    logic [7:0]  ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_flag_capture #(
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sum          (sum),
        .sign         (sign),
        .zero         (zero),
        .carry        (carry),
        .parity       (parity),
        .overflow     (overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_flags    (out_flags),
        .clr_stat     (clr_stat),
        .sticky_flags (sticky_flags),
        .carry_count  (carry_count),
        .ovf_count    (ovf_count)
    );

    // One line per accepted transaction on either side.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready)
            $display("[%0t] push sum=%h flags=%b", $time, sum, {sign, zero, carry, parity, overflow});
        if (rst_n && out_valid && out_ready)
            $display("[%0t] pop  sum=%h flags=%b", $time, out_sum, out_flags);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] s, input logic [4:0] f);
        in_valid = v;
        sum      = s;
        {sign, zero, carry, parity, overflow} = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
        set_in(1'b1, 16'h1234, 5'b11111);
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_sum !== 16'h0000 || out_flags !== 5'b00000) begin errors++; $display("FAIL reset_out_data got=%h/%b want=0000/00000", out_sum, out_flags); end
        checks++; if (sticky_flags !== 2'b00 || carry_count !== 8'd0 || ovf_count !== 8'd0) begin errors++; $display("FAIL reset_status got=%b/%0d/%0d want=00/0/0", sticky_flags, carry_count, ovf_count); end
        set_in(1'b0, 16'h0000, 5'b00000);
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_in(1'b1, 16'h000A, 5'b00000);      // 5 + 5
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== 16'h000A || out_flags !== 5'b00000) begin errors++; $display("FAIL basic_first got=%b/%h/%b want=1/000a/00000", out_valid, out_sum, out_flags); end
        checks++; if (carry_count !== 8'd0 || ovf_count !== 8'd0) begin errors++; $display("FAIL basic_counts got=%0d/%0d want=0/0", carry_count, ovf_count); end
        set_in(1'b1, 16'h1234, 5'b10010);      // flags must pass through as given
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== 16'h1234 || out_flags !== 5'b10010) begin errors++; $display("FAIL basic_second got=%b/%h/%b want=1/1234/10010", out_valid, out_sum, out_flags); end
        set_in(1'b0, 16'h0000, 5'b00000);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 16'h000D, 5'b00010);      // 6 + 7, odd parity
        tick();
        checks++; if (in_ready !== 1'b1 || out_sum !== 16'h000D || out_flags !== 5'b00010) begin errors++; $display("FAIL bp_first got=%b/%h/%b want=1/000d/00010", in_ready, out_sum, out_flags); end
        set_in(1'b1, 16'h0017, 5'b00000);
        tick();
        checks++; if (in_ready !== 1'b0 || out_sum !== 16'h000D) begin errors++; $display("FAIL bp_full got=%b/%h want=0/000d", in_ready, out_sum); end
        set_in(1'b1, 16'h0099, 5'b00000);      // must be refused
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h000D) begin errors++; $display("FAIL bp_hold got=%b/%b/%h want=0/1/000d", in_ready, out_valid, out_sum); end
        set_in(1'b0, 16'h0000, 5'b00000);
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_sum !== 16'h0017) begin errors++; $display("FAIL bp_pop1 got=%b/%b/%h want=1/1/0017", in_ready, out_valid, out_sum); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_refused_entry got=%b want=0", out_valid); end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        set_in(1'b1, 16'h0000, 5'b01100);      // 0xFFFF + 1
        tick();
        checks++; if (sticky_flags !== 2'b10 || carry_count !== 8'd1 || ovf_count !== 8'd0) begin errors++; $display("FAIL sticky_carry got=%b/%0d/%0d want=10/1/0", sticky_flags, carry_count, ovf_count); end
        set_in(1'b1, 16'h8000, 5'b10011);      // 0x7FFF + 1
        tick();
        checks++; if (sticky_flags !== 2'b11 || carry_count !== 8'd1 || ovf_count !== 8'd1) begin errors++; $display("FAIL sticky_ovf got=%b/%0d/%0d want=11/1/1", sticky_flags, carry_count, ovf_count); end
        checks++; if (out_sum !== 16'h8000 || out_flags !== 5'b10011) begin errors++; $display("FAIL sticky_data got=%h/%b want=8000/10011", out_sum, out_flags); end
        set_in(1'b0, 16'h0000, 5'b00101);      // flags without a push count nothing
        tick();
        checks++; if (carry_count !== 8'd1 || ovf_count !== 8'd1) begin errors++; $display("FAIL sticky_no_push got=%0d/%0d want=1/1", carry_count, ovf_count); end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        checks++; if (sticky_flags !== 2'b00 || carry_count !== 8'd0 || ovf_count !== 8'd0) begin errors++; $display("FAIL sticky_clear got=%b/%0d/%0d want=00/0/0", sticky_flags, carry_count, ovf_count); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        set_in(1'b1, 16'h8000, 5'b00001);
        for (int i = 0; i < 255; i++) tick();
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_at_255 got=%0d want=255", ovf_count); end
        for (int i = 0; i < 45; i++) tick();
        checks++; if (ovf_count !== 8'd255 || carry_count !== 8'd0 || sticky_flags !== 2'b01) begin errors++; $display("FAIL sat_300 got=%0d/%0d/%b want=255/0/01", ovf_count, carry_count, sticky_flags); end
        clr_stat = 1'b1;                       // clear with a qualifying push
        tick();
        clr_stat = 1'b0;
        checks++; if (ovf_count !== 8'd1 || sticky_flags !== 2'b01) begin errors++; $display("FAIL sat_clear_push got=%0d/%b want=1/01", ovf_count, sticky_flags); end
        set_in(1'b0, 16'h0000, 5'b00000);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pres [6];
        logic [15:0] expd [6];
        pres = '{16'h0102, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
        expd = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
        out_ready = 1'b0;
        set_in(1'b1, 16'h0100, 5'b00000); tick();
        set_in(1'b1, 16'h0101, 5'b00000); tick();
        checks++; if (in_ready !== 1'b0 || out_sum !== 16'h0100) begin errors++; $display("FAIL b2b_full got=%b/%h want=0/0100", in_ready, out_sum); end
        out_ready = 1'b1;
        // First cycle only pops (ready is low), so 0x0102 is offered twice.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, pres[i], 5'b00000);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== expd[i] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_step%0d got=%b/%h/%b want=1/%h/1", i, out_valid, out_sum, in_ready, expd[i]);
            end
        end
        set_in(1'b0, 16'h0000, 5'b00000);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(1'b1, 16'h0000, 5'b01100); tick();
        set_in(1'b1, 16'h8000, 5'b10011); tick();
        checks++; if (in_ready !== 1'b0 || sticky_flags !== 2'b11) begin errors++; $display("FAIL mid_full got=%b/%b want=0/11", in_ready, sticky_flags); end
        rst_n = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 16'h0000) begin errors++; $display("FAIL mid_reset_buf got=%b/%b/%h want=0/0/0000", out_valid, in_ready, out_sum); end
        checks++; if (sticky_flags !== 2'b00 || carry_count !== 8'd0 || ovf_count !== 8'd0) begin errors++; $display("FAIL mid_reset_status got=%b/%0d/%0d want=00/0/0", sticky_flags, carry_count, ovf_count); end
        rst_n = 1'b1;
        set_in(1'b0, 16'h0000, 5'b00000);
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got=%b/%b want=1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sticky();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_capture.md
# alu_flag_capture

Registered result stage directly downstream of the 16-bit flag-producing `ALU` (`sum`, `sign`, `zero`, `carry`, `parity`, `overflow`). It captures each valid ALU result into a 2-entry skid buffer with a valid/ready handshake toward the consumer. It also keeps sticky carry/overflow status and saturating event counters for software readback. The ALU is combinational, so this block is the first register point after it.

## Interface

- `WIDTH`, 16: datapath width; must match ALU `sum`
- `CNT_W`, 8: width of each event counter
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: one clock; reset is synchronous and active-low
- `in_valid` in 1: ALU outputs carry a valid result this cycle
- `in_ready` out 1: block can accept a result this cycle
- `sum` in WIDTH: ALU sum
- `sign`, `zero`, `carry`, `parity`, `overflow` in 1 each: ALU flags
- `out_valid` out 1: head entry valid
- `out_ready` in 1: consumer takes the head entry
- `out_sum` out WIDTH: head entry sum
- `out_flags` out 5: head entry flags, bit order {sign, zero, carry, parity, overflow} (bit 4 to bit 0)
- `clr_stat` in 1: clears the sticky bits and both counters
- `sticky_flags` out 2: {carry_seen, overflow_seen}
- `carry_count` out CNT_W: number of accepted results with `carry`=1
- `ovf_count` out CNT_W: number of accepted results with `overflow`=1

## Operation

- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`. Storage is 2 entries of {sum, flags}, in FIFO order.
- Occupancy 0 to 2:
  - push without pop: +1
  - pop without push: −1
  - push and pop together: unchanged, and the new entry goes behind the remaining one.
- `in_ready` is registered and equals "occupancy after this edge < 2". When full, it deasserts the cycle after the second push. A pop while full re-asserts it the next cycle; there is no same-cycle pass-through when full.
- `out_valid` equals "occupancy > 0". `out_sum`/`out_flags` are driven from the head register only; there is no combinational path from `sum` to `out_sum`.
- With `out_valid`=1 and `out_ready`=0, the head is held stable. Flags pass through unmodified; the block does not recompute them.
- Sticky bits:
  - `carry_seen` sets on any push with `carry`=1.
  - `overflow_seen` sets on any push with `overflow`=1.
  - `clr_stat` clears both. If a clear and a setting push occur in the same cycle, set wins.
- Counters:
  - Increment by 1 per qualifying push and saturate at 2^CNT_W−1 (no wrap).
  - `clr_stat` sets them to 0. With a qualifying push in the same cycle, the result is 1.
- A push is qualified only by the handshake. Flags on cycles without an accepted push are ignored.

## Timing

- Latency: a push into an empty buffer at edge N makes `out_valid`=1 with that data after edge N (visible in cycle N+1).
- Throughput: 1 result/cycle while the consumer holds `out_ready`=1.
- Reset values while `rst_n`=0, and after the reset edge:
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_flags`=0
  - `sticky_flags`=0, `carry_count`=0, `ovf_count`=0
  - occupancy=0
- `in_ready` rises on the first edge with `rst_n` sampled high.
- Reset mid-operation discards all buffered entries and status the same edge. A handshake in a reset cycle has no effect.
- Status outputs are registered and update one edge after the qualifying push or clear.

## Structure

- Shared package `alu_pkg` holds:
  - `ALU_WIDTH`=16
  - flag index constants `FLAG_SIGN`=4, `FLAG_ZERO`=3, `FLAG_CARRY`=2, `FLAG_PARITY`=1, `FLAG_OVF`=0
  - typedef `alu_flags_t` (5-bit packed)
  - typedef `alu_result_t` {sum, flags}
- One sub-module, `sat_counter` (params `W`; ports `clk`, `rst_n`, `clr`, `inc`, `count`), is instantiated twice for the event counters.

## Test plan

- Reset, then push x=5,y=5 (sum=0x000A) with `out_ready`=1 → `out_valid` one cycle later, `out_sum`=0x000A, flags pass through unchanged, counters 0.
- Hold `out_ready`=0 and push 0x000D and 0x0017 → `in_ready` drops after the second push, the third `in_valid` is not accepted, and the head stays 0x000D.
- Push x=0xFFFF+1 (sum=0x0000, zero=1, carry=1) → `carry_seen`=1, `carry_count`=1. Push 0x7FFF+1 (sum=0x8000, sign=1, overflow=1) → `overflow_seen`=1, `ovf_count`=1.
- With CNT_W=8, 300 overflow pushes → `ovf_count`=255, no wrap. `clr_stat` together with an overflow push → `ovf_count`=1, `overflow_seen`=1.
- Full buffer, with `out_ready` and `in_valid` both held high → one result per cycle after recovery, FIFO order preserved.
- Assert `rst_n`=0 with 2 entries buffered → next cycle `out_valid`=0, all status 0, `in_ready`=0. `in_ready`=1 the cycle after `rst_n` returns high.
